dt1_mem_arbiter: RTL

- Shares one single-port, word-wide synchronous memory (1-cycle read latency) between the core's instruction-fetch port and its load/store port.
- The core sees two independent request/grant/response channels.
- Sits between dt1_top and the unified program/data memory, replacing a dual-ported memory model.
- Data accesses have priority. A streak counter guarantees fetch forward progress. Misaligned data accesses are rejected without touching memory.

---
 rtl/dt1_mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dt1_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between the fetch and load/store channels.
// Data accesses win unless a pending fetch has watched MAX_D_STREAK data grants in a row.
module dt1_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned MEM_WORDS    = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_gnt,
    output logic                         i_rvalid,
    output logic [31:0]                  i_rdata,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [1:0]                   d_size,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [31:0]                  d_wdata,
    input  logic [3:0]                   d_be,
    output logic                         d_gnt,
    output logic                         d_rvalid,
    output logic [31:0]                  d_rdata,
    output logic                         d_err,
    output logic                         mem_en,
    output logic [3:0]                   mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_INSTR,
        TAG_DATA,
        TAG_DATA_ERR
    } tag_e;

    tag_e             tag_q, tag_d;
    logic             store_q, store_d;
    logic [CNT_W-1:0] streak_q, streak_d;
    logic [31:0]      i_hold_q;
    logic [31:0]      d_hold_q;
    logic             d_misalign_c;
    logic             streak_full_c;
    logic             unused_addr_c;

    assign unused_addr_c = ^{i_addr[ADDR_W-1:IDX_W+2], i_addr[1:0], d_addr[ADDR_W-1:IDX_W+2]};

    // Grant selection, memory command and next-state for the response tag and streak
    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        tag_d     = TAG_NONE;
        store_d   = 1'b0;
        streak_d  = streak_q;

        d_misalign_c  = (d_size == 2'd3) ||
                        ((d_size == 2'd1) && d_addr[0]) ||
                        ((d_size == 2'd2) && (d_addr[1:0] != 2'b00));
        streak_full_c = (streak_q == CNT_W'(MAX_D_STREAK));

        // Grants are forced low while reset is held so nothing leaks onto mem_*
        if (!rst) begin
            d_gnt = d_req && !(streak_full_c && i_req);
            i_gnt = i_req && !d_gnt;
        end

        if (d_gnt) begin
            tag_d = d_misalign_c ? TAG_DATA_ERR : TAG_DATA;
            if (!d_misalign_c) begin
                mem_en   = 1'b1;
                mem_addr = d_addr[IDX_W+1:2];
                store_d  = d_we;
                if (d_we) begin
                    mem_we    = d_be;
                    mem_wdata = d_wdata;
                end
            end
        end else if (i_gnt) begin
            tag_d    = TAG_INSTR;
            mem_en   = 1'b1;
            mem_addr = i_addr[IDX_W+1:2];
        end

        if (!i_req || i_gnt) begin
            streak_d = '0;
        end else if (d_gnt && !streak_full_c) begin
            streak_d = streak_q + CNT_W'(1);
        end
    end

    // Response steering; a channel without a response keeps showing its last word
    always_comb begin
        i_rvalid = (tag_q == TAG_INSTR);
        d_rvalid = (tag_q == TAG_DATA) || (tag_q == TAG_DATA_ERR);
        d_err    = (tag_q == TAG_DATA_ERR);
        i_rdata  = i_rvalid ? mem_rdata : i_hold_q;
        d_rdata  = d_hold_q;
        if (tag_q == TAG_DATA_ERR) begin
            d_rdata = 32'h0;
        end else if (tag_q == TAG_DATA) begin
            d_rdata = store_q ? 32'h0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q    <= TAG_NONE;
            store_q  <= 1'b0;
            streak_q <= '0;
            i_hold_q <= 32'h0;
            d_hold_q <= 32'h0;
        end else begin
            tag_q    <= tag_d;
            store_q  <= store_d;
            streak_q <= streak_d;
            i_hold_q <= i_rdata;
            d_hold_q <= d_rdata;
        end
    end

endmodule
